freq_hop_sched: RTL and testbench
=================================

FREQ_HOP_SCHED -- requirements
Module: freq_hop_sched

Interface
REQ-001 SHALL provide parameter NUM_CH, default 6, meaning the number of hop channels, with words 0..NUM_CH-1 and NUM_CH <= 8.
REQ-002 SHALL provide parameter DWELL_W, default 16, meaning the width of the dwell length input.
REQ-003 SHALL provide parameter SETTLE, default 4, meaning the NCO settle (blanking) cycles after each hop, with SETTLE >= 1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port en, input, 1 bit: clock enable; when 0, all state is frozen.
REQ-007 SHALL have port start, input, 1 bit: single-cycle request to begin a hop sequence.
REQ-008 SHALL have port stop, input, 1 bit: single-cycle request to abort the sequence.
REQ-009 SHALL have port mode, input, 1 bit: 0 = sequential hop order, 1 = pseudo-random hop order; sampled on an accepted start.
REQ-010 SHALL have port dwell, input, DWELL_W bits: dwell cycles per channel; sampled on an accepted start.
REQ-011 SHALL have port word, output, 3 bits: channel select that drives the frequency-control word decoder.
REQ-012 SHALL have port hop, output, 1 bit: one-cycle pulse in the first cycle a new word value is presented.
REQ-013 SHALL have port settled, output, 1 bit: 1 during the dwell phase, when downstream samples are valid.
REQ-014 SHALL have port busy, output, 1 bit: 1 in any state other than IDLE.
REQ-015 SHALL have port hop_cnt, output, 16 bits: count of hops since the last accepted start; wraps from 16'hFFFF to 0.

Function
REQ-016 SHALL implement an FSM with states IDLE, SETTLE, DWELL.
REQ-017 SHALL accept start only in IDLE with en=1 and stop=0.
- On acceptance: latch mode; latch dwell, with 0 replaced by 1.
- Next cycle: state SETTLE, word = first channel, hop=1, hop_cnt=1.
REQ-018 SHALL ignore start while busy=1.
REQ-019 SHALL remain in SETTLE for exactly SETTLE enabled cycles, with settled=0, then enter DWELL.
REQ-020 SHALL remain in DWELL for exactly the latched dwell count of enabled cycles, with settled=1.
- Then: word advances to the next channel, hop=1, hop_cnt increments, state returns to SETTLE.
- The hop period is therefore SETTLE + dwell cycles.
REQ-021 SHALL, in sequential mode, use first channel 0 and next = word+1, wrapping NUM_CH-1 -> 0.
REQ-022 SHALL, in pseudo-random mode, hold a 7-bit LFSR (x^7+x^6+1) that reset loads with 7'h01 and that advances once per hop (including the first), with the candidate channel derived as follows:
- c = lfsr[2:0] of the advanced value.
- If c >= NUM_CH, c -= NUM_CH.
- If c equals the current word, c = (c+1) mod NUM_CH.
- The first hop uses c without the repeat check.
REQ-023 SHALL treat a stop (en=1) in SETTLE or DWELL as follows:
- Next cycle: IDLE, busy=0, settled=0, hop=0.
- word and hop_cnt hold their values.
- The LFSR is not reset.
REQ-024 SHALL give stop priority when start and stop are asserted together; the state stays IDLE.
REQ-025 SHALL, on a stop coinciding with the final DWELL cycle, return to IDLE with no hop and word unchanged.
REQ-026 SHALL, when en=0:
- freeze the FSM, counters, LFSR and all outputs;
- ignore start and stop;
- never extend a hop pulse, so hop=0 while en=0.
REQ-027 SHALL always hold word within 0..NUM_CH-1.
REQ-028 SHALL drive hop as a registered output, high for exactly one enabled cycle per hop.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, regardless of en, set the following on the next cycle:
- state IDLE, word=0, hop=0, settled=0, busy=0, hop_cnt=0, LFSR=7'h01;
- latched dwell=1, latched mode=0.
REQ-030 SHALL obey a reset asserted mid-sequence within one cycle, with no further hop pulse.

Verification
REQ-031 SHALL be verified sequentially: mode=0, dwell=3, start at cycle 10 -> word 0,1,2,3,4,5,0 starting at cycles 11,18,25,...; hop pulses every 7 cycles; settled high on cycles 15-17, 22-24, ...; hop_cnt=7 at cycle 53.
REQ-032 SHALL be verified pseudo-randomly: mode=1, dwell=5, 200 hops -> word always < 6; no two consecutive words equal; word sequence matches the reference LFSR model.
REQ-033 SHALL be verified for stop: stop on the 2nd DWELL cycle of hop 3 -> busy=0 next cycle; word stays 2; hop_cnt stays 3; a subsequent start restarts at word 0 with hop_cnt=1.
REQ-034 SHALL be verified for corner cases:
- dwell=0 -> behaves as dwell=1, with a period of SETTLE+1=5 cycles.
- start and stop together in IDLE -> busy stays 0.
- start while busy -> no effect on the sequence.
REQ-035 SHALL be verified for en: en=0 for 10 cycles during DWELL -> all outputs constant; after en returns to 1, the remaining dwell cycles complete unchanged and hop timing shifts by exactly 10 cycles.
REQ-036 SHALL be verified for reset: rst pulse during SETTLE of hop 4 -> next cycle word=0, busy=0, hop_cnt=0; no hop pulse until the next start.

Source files
------------

// File: rtl/freq_hop_sched.sv
// Frequency-hop scheduler.
// Steps a channel select through a sequential or LFSR-driven order. Each hop
// is followed by an NCO blanking window (SETTLE cycles) and then a dwell
// window in which downstream samples are valid. Clock enable freezes everything.
module freq_hop_sched #(
   parameter int NUM_CH  = 6,
   parameter int DWELL_W = 16,
   parameter int SETTLE  = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               start,
   input  logic               stop,
   input  logic               mode,
   input  logic [DWELL_W-1:0] dwell,
   output logic [2:0]         word,
   output logic               hop,
   output logic               settled,
   output logic               busy,
   output logic [15:0]        hop_cnt
);

   // Settle counter only needs to hold SETTLE-1.
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
   localparam logic [2:0]    LAST_CH     = 3'(NUM_CH - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_DWELL
   } state_t;

   state_t             state;
   logic [SW-1:0]      settle_cnt;
   logic [DWELL_W-1:0] dwell_cnt;
   logic [DWELL_W-1:0] dwell_lat;
   logic               mode_lat;
   logic [6:0]         lfsr;
   logic               hop_q;

   logic [6:0]         lfsr_adv;
   logic [2:0]         rand_first;
   logic [2:0]         rand_next;
   logic [2:0]         seq_next;

   // One step of the x^7 + x^6 + 1 Fibonacci LFSR (shift left, feedback into bit 0).
   function automatic logic [6:0] lfsr_step(input logic [6:0] s);
      return {s[5:0], s[6] ^ s[5]};
   endfunction

   // Fold a 3-bit value into the channel range 0..NUM_CH-1.
   function automatic logic [2:0] fold_ch(input logic [2:0] c);
      logic [3:0] t;
      t = {1'b0, c};
      for (int i = 0; i < 8; i++) begin
         if (t >= 4'(NUM_CH)) t = t - 4'(NUM_CH);
      end
      return t[2:0];
   endfunction

   // Step past the current channel so a hop never lands on the same word.
   function automatic logic [2:0] avoid_repeat(input logic [2:0] c, input logic [2:0] cur);
      if (c != cur) return c;
      return (c == LAST_CH) ? 3'd0 : c + 3'd1;
   endfunction

   // Candidate channels for the next hop in each ordering mode.
   always_comb begin
      lfsr_adv   = lfsr_step(lfsr);
      rand_first = fold_ch(lfsr_adv[2:0]);
      rand_next  = avoid_repeat(rand_first, word);
      seq_next   = (word == LAST_CH) ? 3'd0 : word + 3'd1;
   end

   // Hop sequencing FSM with registered outputs; en=0 freezes all state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         word       <= 3'd0;
         hop_q      <= 1'b0;
         settled    <= 1'b0;
         busy       <= 1'b0;
         hop_cnt    <= 16'd0;
         lfsr       <= 7'h01;
         dwell_lat  <= DWELL_W'(1);
         mode_lat   <= 1'b0;
         settle_cnt <= '0;
         dwell_cnt  <= '0;
      end else if (en) begin
         hop_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start && !stop) begin
                  state      <= ST_SETTLE;
                  busy       <= 1'b1;
                  settled    <= 1'b0;
                  hop_q      <= 1'b1;
                  hop_cnt    <= 16'd1;
                  settle_cnt <= SETTLE_LAST;
                  mode_lat   <= mode;
                  dwell_lat  <= (dwell == '0) ? DWELL_W'(1) : dwell;
                  if (mode) begin
                     lfsr <= lfsr_adv;
                     word <= rand_first;
                  end else begin
                     word <= 3'd0;
                  end
               end
            end
            ST_SETTLE: begin
               if (stop) begin
                  state   <= ST_IDLE;
                  busy    <= 1'b0;
                  settled <= 1'b0;
               end else if (settle_cnt == '0) begin
                  state     <= ST_DWELL;
                  settled   <= 1'b1;
                  dwell_cnt <= dwell_lat - DWELL_W'(1);
               end else begin
                  settle_cnt <= settle_cnt - SW'(1);
               end
            end
            ST_DWELL: begin
               if (stop) begin
                  state   <= ST_IDLE;
                  busy    <= 1'b0;
                  settled <= 1'b0;
               end else if (dwell_cnt == '0) begin
                  state      <= ST_SETTLE;
                  settled    <= 1'b0;
                  hop_q      <= 1'b1;
                  hop_cnt    <= hop_cnt + 16'd1;
                  settle_cnt <= SETTLE_LAST;
                  if (mode_lat) begin
                     lfsr <= lfsr_adv;
                     word <= rand_next;
                  end else begin
                     word <= seq_next;
                  end
               end else begin
                  dwell_cnt <= dwell_cnt - DWELL_W'(1);
               end
            end
            default: begin
               state   <= ST_IDLE;
               busy    <= 1'b0;
               settled <= 1'b0;
            end
         endcase
      end
   end

   // The hop flag is held through a freeze so its one enabled cycle is not
   // lost, but it is masked while en=0 so a pulse is never stretched.
   assign hop = hop_q & en;

endmodule

// File: tb/tb_freq_hop_sched.sv
// Bench for freq_hop_sched: directed scenarios plus random traffic, every
// cycle compared against a period-position reference model.
module tb_freq_hop_sched;

   localparam int NUM_CH  = 6;
   localparam int DWELL_W = 16;
   localparam int SETTLE  = 4;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               en = 1'b1;
   logic               start = 1'b0;
   logic               stop = 1'b0;
   logic               mode = 1'b0;
   logic [DWELL_W-1:0] dwell = '0;
   logic [2:0]         word;
   logic               hop;
   logic               settled;
   logic               busy;
   logic [15:0]        hop_cnt;

   always #5 clk = ~clk;

   freq_hop_sched #(.NUM_CH(NUM_CH), .DWELL_W(DWELL_W), .SETTLE(SETTLE)) dut (
      .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop), .mode(mode),
      .dwell(dwell), .word(word), .hop(hop), .settled(settled), .busy(busy),
      .hop_cnt(hop_cnt)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, obs, exp);
      end
   endtask

   // Reference model: position within the current hop period.
   logic [6:0] lseq [127];
   int  m_idx;
   bit  m_act;
   int  m_pos;
   int  m_per;
   int  m_word;
   int  m_cnt;
   bit  m_mode;
   bit  m_valid = 1'b0;

   function automatic int next_word(input bit first);
      int c;
      if (!m_mode) return first ? 0 : (m_word + 1) % NUM_CH;
      m_idx = (m_idx + 1) % 127;
      c = int'(lseq[m_idx] & 7'h07);
      if (c >= NUM_CH) c -= NUM_CH;
      if (!first && c == m_word) c = (c + 1) % NUM_CH;
      return c;
   endfunction

   task automatic model_edge();
      if (rst) begin
         m_act = 0; m_pos = 0; m_per = SETTLE + 1; m_word = 0; m_cnt = 0;
         m_idx = 0; m_mode = 0; m_valid = 1;
      end else if (en) begin
         if (m_act) begin
            if (stop) m_act = 0;
            else begin
               m_pos++;
               if (m_pos == m_per) begin
                  m_pos  = 0;
                  m_cnt  = (m_cnt + 1) % 65536;
                  m_word = next_word(1'b0);
               end
            end
         end else if (start && !stop) begin
            m_act  = 1;
            m_pos  = 0;
            m_mode = mode;
            m_per  = SETTLE + ((dwell == 0) ? 1 : int'(dwell));
            m_cnt  = 1;
            m_word = next_word(1'b1);
         end
      end
   endtask

   task automatic model_check();
      if (m_valid) begin
         chk("word", 32'(word), m_word);
         chk("busy", 32'(busy), 32'(m_act));
         chk("settled", 32'(settled), 32'(m_act && m_pos >= SETTLE));
         chk("hop", 32'(hop), 32'(m_act && m_pos == 0 && en));
         chk("hop_cnt", 32'(hop_cnt), m_cnt);
      end
   endtask

   // Inputs are set at edge+1; outputs checked at edge+2; model steps on the edge.
   task automatic cycle();
      #1;
      model_check();
      @(posedge clk);
      model_edge();
      #1;
      cyc++;
   endtask

   task automatic do_start(input bit md, input int dw);
      start = 1'b1; mode = md; dwell = DWELL_W'(dw);
      cycle();
      start = 1'b0;
   endtask

   task automatic do_stop();
      stop = 1'b1;
      cycle();
      stop = 1'b0;
      cycle();
   endtask

   int prev;
   int hops;
   int budget;
   logic [2:0]  sv_word;
   logic [15:0] sv_cnt;

   initial begin
      lseq[0] = 7'h01;
      for (int i = 0; i < 126; i++)
         lseq[i+1] = {lseq[i][5:0], lseq[i][6] ^ lseq[i][5]};

      // Reset, then idle up to cycle 10
      rst = 1'b1;
      cycle(); cycle();
      rst = 1'b0;
      chk("rst_word", 32'(word), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_cnt", 32'(hop_cnt), 0);
      while (cyc < 10) cycle();

      // Sequential order, dwell=3, start at cycle 10
      do_start(1'b0, 3);
      while (cyc <= 60) begin
         if ((cyc - 11) % 7 == 0) begin
            chk("seq_word", 32'(word), ((cyc - 11) / 7) % 6);
            chk("seq_hop", 32'(hop), 1);
         end
         if (cyc >= 15) chk("seq_settled", 32'(settled), 32'(((cyc - 15) % 7) < 3));
         if (cyc == 53) chk("seq_cnt53", 32'(hop_cnt), 7);
         cycle();
      end
      do_stop();
      chk("seq_stopped", 32'(busy), 0);

      // Pseudo-random order, dwell=5, 200 hops
      do_start(1'b1, 5);
      prev = -1; hops = 0; budget = 200 * 9 + 50;
      while (hops < 200 && budget > 0) begin
         if (hop) begin
            chk("rnd_range", 32'(word < 3'(NUM_CH)), 1);
            if (prev >= 0) chk("rnd_repeat", 32'(int'(word) == prev), 0);
            prev = int'(word);
            hops++;
         end
         cycle();
         budget--;
      end
      chk("rnd_hops", hops, 200);
      do_stop();

      // Stop on the 2nd dwell cycle of hop 3
      cycle();
      do_start(1'b0, 3);
      for (int k = 0; k < 19; k++) cycle();
      chk("stop_in_dwell", 32'(settled), 1);
      stop = 1'b1;
      cycle();
      stop = 1'b0;
      chk("stop_busy", 32'(busy), 0);
      chk("stop_word", 32'(word), 2);
      chk("stop_cnt", 32'(hop_cnt), 3);
      cycle(); cycle();
      chk("stop_hold", 32'(word), 2);
      do_start(1'b0, 3);
      chk("restart_word", 32'(word), 0);
      chk("restart_cnt", 32'(hop_cnt), 1);
      chk("restart_hop", 32'(hop), 1);
      do_stop();

      // start+stop together in IDLE, then dwell=0 with a start while busy
      start = 1'b1; stop = 1'b1;
      cycle();
      start = 1'b0; stop = 1'b0;
      chk("startstop_busy", 32'(busy), 0);
      cycle();
      do_start(1'b0, 0);
      for (int k = 0; k < 15; k++) begin
         chk("dw0_hop", 32'(hop), 32'(k % 5 == 0));
         if (k == 7) begin start = 1'b1; mode = 1'b1; dwell = 16'd7; end
         cycle();
         start = 1'b0;
      end
      chk("busy_start_word", 32'(word), 3);
      do_stop();

      // en=0 for 10 cycles in the middle of a dwell
      do_start(1'b0, 6);
      for (int k = 0; k < 6; k++) cycle();
      sv_word = word; sv_cnt = hop_cnt;
      en = 1'b0;
      for (int k = 0; k < 10; k++) begin
         chk("frz_word", 32'(word), 32'(sv_word));
         chk("frz_cnt", 32'(hop_cnt), 32'(sv_cnt));
         chk("frz_settled", 32'(settled), 1);
         chk("frz_busy", 32'(busy), 1);
         cycle();
      end
      en = 1'b1;
      for (int k = 16; k <= 20; k++) begin
         chk("en_hop", 32'(hop), 32'(k == 20));
         cycle();
      end
      do_stop();

      // Reset during SETTLE of hop 4
      do_start(1'b0, 3);
      for (int k = 0; k < 22; k++) cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("mid_rst_word", 32'(word), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_cnt", 32'(hop_cnt), 0);
      for (int k = 0; k < 20; k++) begin
         chk("mid_rst_nohop", 32'(hop), 0);
         cycle();
      end

      // Random traffic
      for (int k = 0; k < 3000; k++) begin
         rst   = ($urandom % 300) == 0;
         en    = ($urandom % 8) != 0;
         start = ($urandom % 12) == 0;
         stop  = ($urandom % 40) == 0;
         mode  = $urandom % 2;
         dwell = DWELL_W'($urandom % 5);
         cycle();
      end
      rst = 1'b0; en = 1'b1; start = 1'b0; stop = 1'b0;
      cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
